fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode/execute datapath from `instructionMemory`. Holds the program counter and drives `address`. Samples the combinational `instruction` return into an instruction register and hands it downstream over a valid/ready handshake. Handles start, halt detection (opcode 1110), branch redirect, and program-switch restart.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the program counter (driven on address), samples the combinational
// instruction return into an instruction register and offers it downstream
// over a valid/ready handshake. Handles start, halt detection, branch
// redirect and program-switch restart.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   programSelect  board switches; any change restarts into IDLE
//   start          begin fetching from address 0 (from IDLE or HALTED)
//   address        program counter, straight to instruction memory
//   instruction    combinational memory data for address
//   instrOut       instruction register
//   instrValid     instrOut holds an unconsumed instruction
//   instrReady     downstream accepts instrOut this cycle
//   instrPc        address instrOut was fetched from
//   branchValid    redirect request (honoured in FETCH/DRAIN only)
//   branchTarget   redirect address
//   halted         high while stopped after a HALT instruction
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'b1110
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             programSelect,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic                   instrValid,
  input  logic                   instrReady,
  output logic [ADDR_WIDTH-1:0]  instrPc,
  input  logic                   branchValid,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic                   halted
);

  localparam int unsigned SEL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
  logic                   valid_q, valid_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   halted_q;

  logic sel_change_c;
  logic is_halt_c;
  logic capture_c;

  assign sel_change_c = (programSelect != sel_q);
  assign is_halt_c    = (instruction[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
  assign capture_c    = !valid_q || instrReady;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // Next-state logic; branches of the if-chain encode event priority
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    sel_d   = sel_q;

    if (sel_change_c) begin
      sel_d   = programSelect;
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else if (branchValid && (state_q == ST_FETCH || state_q == ST_DRAIN)) begin
      // Redirect discards the IR even if it is being accepted this cycle
      pc_d    = branchTarget;
      valid_d = 1'b0;
      state_d = ST_FETCH;
    end else if (start && (state_q == ST_IDLE || state_q == ST_HALTED)) begin
      pc_d    = '0;
      valid_d = 1'b0;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (capture_c) begin
            ir_d    = instruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            if (is_halt_c) begin
              state_d = ST_DRAIN;
            end else begin
              pc_d = pc_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (instrReady) begin
            valid_d = 1'b0;
            state_d = ST_HALTED;
          end
        end
        ST_IDLE:   pc_d = '0;
        ST_HALTED: ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign address    = pc_q;
  assign instrOut   = ir_q;
  assign instrPc    = ipc_q;
  assign instrValid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios against constant
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  programSelect;
  logic        start;
  logic [7:0]  address;
  logic [15:0] instruction;
  logic [15:0] instrOut;
  logic        instrValid;
  logic        instrReady;
  logic [7:0]  instrPc;
  logic        branchValid;
  logic [7:0]  branchTarget;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] rmem [256];
  logic [15:0] prog [6] = '{16'h0102, 16'h2F10, 16'h0203, 16'h2F20, 16'h4F21, 16'hE000};

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .programSelect(programSelect),
    .start        (start),
    .address      (address),
    .instruction  (instruction),
    .instrOut     (instrOut),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instrPc      (instrPc),
    .branchValid  (branchValid),
    .branchTarget (branchTarget),
    .halted       (halted)
  );

  // Instruction memory: 0x04 is the test program, 0xA5 random, others linear
  function automatic logic [15:0] mem_read(input logic [7:0] sel, input logic [7:0] a);
    if (sel == 8'h04) begin
      if (a < 8'd6)        return prog[a];
      else if (a == 8'd16) return 16'h4F78;
      else if (a == 8'd17) return 16'hE000;
      else                 return {8'h30, a};
    end else if (sel == 8'hA5) begin
      return rmem[a];
    end
    return {4'h1, sel[3:0], a};
  endfunction

  assign instruction = mem_read(programSelect, address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model (mode: 0 idle, 1 running, 2 halt pending, 3 stopped)
  int          m_mode;
  logic [7:0]  m_pc, m_ipc, m_sel;
  logic [15:0] m_ir;
  logic        m_valid;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'd0; m_ipc = 8'd0; m_sel = 8'd0; m_ir = 16'd0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] ins;
    ins = mem_read(programSelect, m_pc);
    if (programSelect != m_sel) begin
      m_sel = programSelect; m_pc = 8'd0; m_valid = 1'b0; m_mode = 0;
    end else if (branchValid && (m_mode == 1 || m_mode == 2)) begin
      m_pc = branchTarget; m_valid = 1'b0; m_mode = 1;
    end else if (start && (m_mode == 0 || m_mode == 3)) begin
      m_pc = 8'd0; m_valid = 1'b0; m_mode = 1;
    end else if (m_mode == 1 && (!m_valid || instrReady)) begin
      m_ir = ins; m_ipc = m_pc; m_valid = 1'b1;
      if (ins[15:12] == 4'hE) m_mode = 2;
      else m_pc = m_pc + 8'd1;
    end else if (m_mode == 2 && instrReady) begin
      m_valid = 1'b0; m_mode = 3;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; programSelect = 8'h04; start = 1'b0; instrReady = 1'b0;
    branchValid = 1'b0; branchTarget = 8'd0;
    #12;
    checks++;
    if ({address, instrOut, instrPc, instrValid, halted} !== 34'd0) begin
      errors++;
      $display("FAIL reset_values got addr=%h ir=%h pc=%h v=%b h=%b expected all 0",
               address, instrOut, instrPc, instrValid, halted);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({address, instrValid, halted} !== 10'd0) begin
      errors++;
      $display("FAIL idle_after_reset got addr=%h v=%b h=%b expected 0", address, instrValid, halted);
    end
  endtask

  task automatic test_program();
    start = 1'b1; instrReady = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (address !== 8'd0 || instrValid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency got addr=%h v=%b expected 00/0", address, instrValid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (instrOut !== prog[i] || instrPc !== 8'(i) || instrValid !== 1'b1
          || address !== ((i == 5) ? 8'd5 : 8'(i + 1))) begin
        errors++;
        $display("FAIL prog_seq[%0d] got ir=%h pc=%h v=%b addr=%h expected ir=%h pc=%h",
                 i, instrOut, instrPc, instrValid, address, prog[i], 8'(i));
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instrValid !== 1'b0 || address !== 8'd5) begin
      errors++;
      $display("FAIL halt_after_accept got h=%b v=%b addr=%h expected 1/0/05", halted, instrValid, address);
    end
    repeat (2) tick();
    checks++;
    if (halted !== 1'b1 || address !== 8'd5) begin
      errors++;
      $display("FAIL halted_hold got h=%b addr=%h expected 1/05", halted, address);
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    instrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instrOut !== 16'h2F10 || instrPc !== 8'd1 || address !== 8'd2 || instrValid !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d] got ir=%h pc=%h addr=%h v=%b expected 2f10/01/02/1",
                 i, instrOut, instrPc, address, instrValid);
      end
    end
    instrReady = 1'b1;
    for (int i = 2; i < 6; i++) begin
      tick();
      checks++;
      if (instrOut !== prog[i] || instrPc !== 8'(i) || instrValid !== 1'b1) begin
        errors++;
        $display("FAIL resume[%0d] got ir=%h pc=%h v=%b expected ir=%h", i, instrOut, instrPc, instrValid, prog[i]);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL bp_halt got h=%b expected 1", halted);
    end
  endtask

  task automatic test_branch();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (instrPc !== 8'd3 || address !== 8'd4) begin
      errors++;
      $display("FAIL pre_branch got pc=%h addr=%h expected 03/04", instrPc, address);
    end
    branchValid = 1'b1; branchTarget = 8'd16;
    tick();
    branchValid = 1'b0;
    checks++;
    if (instrValid !== 1'b0 || address !== 8'd16) begin
      errors++;
      $display("FAIL branch_bubble got v=%b addr=%h expected 0/10", instrValid, address);
    end
    tick();
    checks++;
    if (instrOut !== 16'h4F78 || instrPc !== 8'd16 || instrValid !== 1'b1) begin
      errors++;
      $display("FAIL branch_target got ir=%h pc=%h v=%b expected 4f78/10/1", instrOut, instrPc, instrValid);
    end
    tick();
    checks++;
    if (instrOut !== 16'hE000 || instrPc !== 8'd17 || instrValid !== 1'b1) begin
      errors++;
      $display("FAIL branch_halt_instr got ir=%h pc=%h v=%b expected e000/11/1", instrOut, instrPc, instrValid);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instrValid !== 1'b0 || address !== 8'd17) begin
      errors++;
      $display("FAIL branch_halted got h=%b v=%b addr=%h expected 1/0/11", halted, instrValid, address);
    end
  endtask

  task automatic test_switch();
    programSelect = 8'h08;
    tick();
    checks++;
    if (instrValid !== 1'b0 || address !== 8'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL switch_from_halt got v=%b addr=%h h=%b expected 0/00/0", instrValid, address, halted);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    checks++;
    if (instrOut !== 16'h1801 || instrPc !== 8'd1 || address !== 8'd2) begin
      errors++;
      $display("FAIL prog8_run got ir=%h pc=%h addr=%h expected 1801/01/02", instrOut, instrPc, address);
    end
    programSelect = 8'h04; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (instrValid !== 1'b0 || address !== 8'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL switch_midrun got v=%b addr=%h h=%b expected 0/00/0", instrValid, address, halted);
    end
    repeat (2) tick();
    checks++;
    if (instrValid !== 1'b0 || address !== 8'd0) begin
      errors++;
      $display("FAIL start_ignored got v=%b addr=%h expected 0/00", instrValid, address);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({address, instrOut, instrPc, instrValid, halted} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got addr=%h ir=%h pc=%h v=%b h=%b expected all 0",
               address, instrOut, instrPc, instrValid, halted);
    end
    #2;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (instrOut !== 16'h0102 || instrPc !== 8'd0 || instrValid !== 1'b1 || address !== 8'd1) begin
      errors++;
      $display("FAIL restart_after_reset got ir=%h pc=%h v=%b addr=%h expected 0102/00/1/01",
               instrOut, instrPc, instrValid, address);
    end
  endtask

  task automatic test_pc_wrap();
    branchValid = 1'b1; branchTarget = 8'd255;
    tick();
    branchValid = 1'b0;
    checks++;
    if (address !== 8'd255 || instrValid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_branch got addr=%h v=%b expected ff/0", address, instrValid);
    end
    tick();
    checks++;
    if (instrOut !== 16'h30FF || instrPc !== 8'd255 || address !== 8'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_255 got ir=%h pc=%h addr=%h h=%b expected 30ff/ff/00/0", instrOut, instrPc, address, halted);
    end
    tick();
    checks++;
    if (instrOut !== 16'h0102 || instrPc !== 8'd0 || address !== 8'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_0 got ir=%h pc=%h addr=%h h=%b expected 0102/00/01/0", instrOut, instrPc, address, halted);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(7) == 0) v[15:12] = 4'hE;
      else if (v[15:12] == 4'hE) v[15:12] = 4'h0;
      rmem[i] = v;
    end
    rst_n = 1'b0; programSelect = 8'hA5; start = 1'b0; branchValid = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      start        = ($urandom_range(3) == 0);
      instrReady   = ($urandom_range(3) != 0);
      branchValid  = ($urandom_range(15) == 0);
      branchTarget = 8'($urandom);
      if ($urandom_range(63) == 0) programSelect = (programSelect == 8'hA5) ? 8'h5A : 8'hA5;
      model_step();
      tick();
      checks++;
      if (address !== m_pc) begin
        errors++;
        $display("FAIL rand_addr cyc %0d got %h expected %h", c, address, m_pc);
      end
      checks++;
      if (instrValid !== m_valid) begin
        errors++;
        $display("FAIL rand_valid cyc %0d got %b expected %b", c, instrValid, m_valid);
      end
      checks++;
      if (halted !== (m_mode == 3)) begin
        errors++;
        $display("FAIL rand_halted cyc %0d got %b expected %b", c, halted, (m_mode == 3));
      end
      checks++;
      if (instrOut !== m_ir || instrPc !== m_ipc) begin
        errors++;
        $display("FAIL rand_ir cyc %0d got %h@%h expected %h@%h", c, instrOut, instrPc, m_ir, m_ipc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_backpressure();
    test_branch();
    test_switch();
    test_async_reset();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
